// File: rtl/uart_stream_core.sv
// UART core: runtime-programmable baud tick, oversampled RX and TX state
// machines, first-word-fall-through FIFOs on both sides, sticky error flags.
module uart_stream_core #(
  parameter int unsigned DBITS      = 8,
  parameter int unsigned SB_TICK    = 16,
  parameter int unsigned DIV_BITS   = 13,
  parameter int unsigned FIFO_EXP   = 4,
  parameter int unsigned PARITY_EN  = 0,
  parameter int unsigned PARITY_ODD = 0
) (
  input  logic                clk_100MHz,
  input  logic                reset,
  input  logic [DIV_BITS-1:0] baud_div,
  input  logic                rx,
  output logic                tx,
  input  logic [DBITS-1:0]    tx_data,
  input  logic                tx_valid,
  output logic                tx_ready,
  output logic [DBITS-1:0]    rx_data,
  output logic                rx_valid,
  input  logic                rx_ready,
  output logic [FIFO_EXP:0]   rx_count,
  output logic [FIFO_EXP:0]   tx_count,
  output logic                err_frame,
  output logic                err_parity,
  output logic                err_overrun,
  input  logic                err_clear
);

  localparam int unsigned DEPTH  = 2**FIFO_EXP;
  localparam int unsigned CNT_W  = FIFO_EXP + 1;
  localparam int unsigned TICK_W = $clog2((SB_TICK > 16) ? SB_TICK : 16);
  localparam int unsigned BIT_W  = (DBITS > 1) ? $clog2(DBITS) : 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);
  localparam logic PAR_INV = (PARITY_ODD != 0);
  localparam logic HAS_PAR = (PARITY_EN != 0);

  typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_PARITY, RX_STOP} rx_state_e;
  typedef enum logic [2:0] {TX_IDLE, TX_START, TX_DATA, TX_PARITY, TX_STOP} tx_state_e;

  // baud generator
  logic [DIV_BITS-1:0] bcnt_q, bcnt_d, div_q, div_d, div_in;
  logic                tick;

  // rx synchronizer and receiver
  logic                rx_meta_q, rx_sync_q;
  rx_state_e           rx_state_q, rx_state_d;
  logic [TICK_W-1:0]   rx_tick_q, rx_tick_d;
  logic [BIT_W-1:0]    rx_bit_q, rx_bit_d;
  logic [DBITS-1:0]    rx_shift_q, rx_shift_d;
  logic                rx_par_q, rx_par_d;
  logic                rx_push, frame_evt, parity_evt, overrun_evt;

  // transmitter
  tx_state_e           tx_state_q, tx_state_d;
  logic [TICK_W-1:0]   tx_tick_q, tx_tick_d;
  logic [BIT_W-1:0]    tx_bit_q, tx_bit_d;
  logic [DBITS-1:0]    tx_shift_q, tx_shift_d;
  logic                tx_par_q, tx_par_d;
  logic                tx_q, tx_d;
  logic                tx_pop;

  // fifos
  logic [DBITS-1:0]    rx_mem_q [DEPTH];
  logic [DBITS-1:0]    tx_mem_q [DEPTH];
  logic [FIFO_EXP-1:0] rx_wr_q, rx_wr_d, rx_rd_q, rx_rd_d;
  logic [FIFO_EXP-1:0] tx_wr_q, tx_wr_d, tx_rd_q, tx_rd_d;
  logic [CNT_W-1:0]    rx_cnt_q, rx_cnt_d, tx_cnt_q, tx_cnt_d;
  logic                rx_push_ok, rx_pop_ok, tx_push_ok;
  logic [DBITS-1:0]    tx_head;

  // error flags
  logic                err_frame_q, err_frame_d;
  logic                err_parity_q, err_parity_d;
  logic                err_overrun_q, err_overrun_d;

  // Oversample tick; a new divisor is only adopted on wrap so a period is never cut short
  always_comb begin
    div_in = (baud_div < DIV_BITS'(2)) ? DIV_BITS'(2) : baud_div;
    bcnt_d = bcnt_q + DIV_BITS'(1);
    div_d  = div_q;
    tick   = 1'b0;
    if (bcnt_q >= div_q - DIV_BITS'(1)) begin
      bcnt_d = '0;
      div_d  = div_in;
      tick   = 1'b1;
    end
  end

  // Receiver: start validated at mid-bit, data/parity/stop sampled every 16 ticks
  always_comb begin
    rx_state_d = rx_state_q;
    rx_tick_d  = rx_tick_q;
    rx_bit_d   = rx_bit_q;
    rx_shift_d = rx_shift_q;
    rx_par_d   = rx_par_q;
    rx_push    = 1'b0;
    frame_evt  = 1'b0;
    parity_evt = 1'b0;
    unique case (rx_state_q)
      RX_IDLE: begin
        if (!rx_sync_q) begin
          rx_state_d = RX_START;
          rx_tick_d  = '0;
        end
      end
      RX_START: begin
        if (tick) begin
          if (rx_tick_q == TICK_W'(7)) begin
            rx_tick_d  = '0;
            rx_bit_d   = '0;
            rx_state_d = rx_sync_q ? RX_IDLE : RX_DATA;
          end else begin
            rx_tick_d = rx_tick_q + TICK_W'(1);
          end
        end
      end
      RX_DATA: begin
        if (tick) begin
          if (rx_tick_q == TICK_W'(15)) begin
            rx_tick_d  = '0;
            rx_shift_d = {rx_sync_q, rx_shift_q[DBITS-1:1]};
            if (rx_bit_q == BIT_W'(DBITS - 1)) begin
              rx_state_d = HAS_PAR ? RX_PARITY : RX_STOP;
            end else begin
              rx_bit_d = rx_bit_q + BIT_W'(1);
            end
          end else begin
            rx_tick_d = rx_tick_q + TICK_W'(1);
          end
        end
      end
      RX_PARITY: begin
        if (tick) begin
          if (rx_tick_q == TICK_W'(15)) begin
            rx_tick_d  = '0;
            rx_par_d   = rx_sync_q;
            rx_state_d = RX_STOP;
          end else begin
            rx_tick_d = rx_tick_q + TICK_W'(1);
          end
        end
      end
      RX_STOP: begin
        if (tick) begin
          if (rx_tick_q == TICK_W'(SB_TICK - 1)) begin
            rx_tick_d  = '0;
            rx_state_d = RX_IDLE;
            frame_evt  = !rx_sync_q;
            parity_evt = HAS_PAR && (rx_par_q != ((^rx_shift_q) ^ PAR_INV));
            rx_push    = !frame_evt && !parity_evt;
          end else begin
            rx_tick_d = rx_tick_q + TICK_W'(1);
          end
        end
      end
      default: rx_state_d = RX_IDLE;
    endcase
  end

  // RX FIFO pointers; a full FIFO still accepts a push when a pop frees a slot
  always_comb begin
    rx_pop_ok   = rx_ready && (rx_cnt_q != '0);
    rx_push_ok  = rx_push && ((rx_cnt_q != FULL_CNT) || rx_pop_ok);
    overrun_evt = rx_push && !rx_push_ok;
    rx_wr_d     = rx_push_ok ? rx_wr_q + FIFO_EXP'(1) : rx_wr_q;
    rx_rd_d     = rx_pop_ok ? rx_rd_q + FIFO_EXP'(1) : rx_rd_q;
    rx_cnt_d    = rx_cnt_q;
    if (rx_push_ok && !rx_pop_ok) begin
      rx_cnt_d = rx_cnt_q + CNT_W'(1);
    end else if (rx_pop_ok && !rx_push_ok) begin
      rx_cnt_d = rx_cnt_q - CNT_W'(1);
    end
  end

  // Transmitter: pops the FIFO head on entry to START, chains frames without idle gap
  always_comb begin
    tx_state_d = tx_state_q;
    tx_tick_d  = tx_tick_q;
    tx_bit_d   = tx_bit_q;
    tx_shift_d = tx_shift_q;
    tx_par_d   = tx_par_q;
    tx_pop     = 1'b0;
    tx_head    = tx_mem_q[tx_rd_q];
    unique case (tx_state_q)
      TX_IDLE: begin
        if (tx_cnt_q != '0) begin
          tx_pop     = 1'b1;
          tx_shift_d = tx_head;
          tx_par_d   = (^tx_head) ^ PAR_INV;
          tx_tick_d  = '0;
          tx_state_d = TX_START;
        end
      end
      TX_START: begin
        if (tick) begin
          if (tx_tick_q == TICK_W'(15)) begin
            tx_tick_d  = '0;
            tx_bit_d   = '0;
            tx_state_d = TX_DATA;
          end else begin
            tx_tick_d = tx_tick_q + TICK_W'(1);
          end
        end
      end
      TX_DATA: begin
        if (tick) begin
          if (tx_tick_q == TICK_W'(15)) begin
            tx_tick_d  = '0;
            tx_shift_d = tx_shift_q >> 1;
            if (tx_bit_q == BIT_W'(DBITS - 1)) begin
              tx_state_d = HAS_PAR ? TX_PARITY : TX_STOP;
            end else begin
              tx_bit_d = tx_bit_q + BIT_W'(1);
            end
          end else begin
            tx_tick_d = tx_tick_q + TICK_W'(1);
          end
        end
      end
      TX_PARITY: begin
        if (tick) begin
          if (tx_tick_q == TICK_W'(15)) begin
            tx_tick_d  = '0;
            tx_state_d = TX_STOP;
          end else begin
            tx_tick_d = tx_tick_q + TICK_W'(1);
          end
        end
      end
      TX_STOP: begin
        if (tick) begin
          if (tx_tick_q == TICK_W'(SB_TICK - 1)) begin
            tx_tick_d = '0;
            if (tx_cnt_q != '0) begin
              tx_pop     = 1'b1;
              tx_shift_d = tx_head;
              tx_par_d   = (^tx_head) ^ PAR_INV;
              tx_state_d = TX_START;
            end else begin
              tx_state_d = TX_IDLE;
            end
          end else begin
            tx_tick_d = tx_tick_q + TICK_W'(1);
          end
        end
      end
      default: tx_state_d = TX_IDLE;
    endcase
    unique case (tx_state_d)
      TX_START:  tx_d = 1'b0;
      TX_DATA:   tx_d = tx_shift_d[0];
      TX_PARITY: tx_d = tx_par_d;
      default:   tx_d = 1'b1;
    endcase
  end

  // TX FIFO pointers; pushes while full are silently dropped
  always_comb begin
    tx_push_ok = tx_valid && (tx_cnt_q != FULL_CNT);
    tx_wr_d    = tx_push_ok ? tx_wr_q + FIFO_EXP'(1) : tx_wr_q;
    tx_rd_d    = tx_pop ? tx_rd_q + FIFO_EXP'(1) : tx_rd_q;
    tx_cnt_d   = tx_cnt_q;
    if (tx_push_ok && !tx_pop) begin
      tx_cnt_d = tx_cnt_q + CNT_W'(1);
    end else if (tx_pop && !tx_push_ok) begin
      tx_cnt_d = tx_cnt_q - CNT_W'(1);
    end
  end

  // Sticky flags: a new event outranks a simultaneous clear
  always_comb begin
    err_frame_d   = frame_evt   || (err_frame_q   && !err_clear);
    err_parity_d  = parity_evt  || (err_parity_q  && !err_clear);
    err_overrun_d = overrun_evt || (err_overrun_q && !err_clear);
  end

  // State registers
  always_ff @(posedge clk_100MHz) begin
    if (reset) begin
      bcnt_q        <= '0;
      div_q         <= div_in;
      rx_meta_q     <= 1'b1;
      rx_sync_q     <= 1'b1;
      rx_state_q    <= RX_IDLE;
      rx_tick_q     <= '0;
      rx_bit_q      <= '0;
      rx_shift_q    <= '0;
      rx_par_q      <= 1'b0;
      tx_state_q    <= TX_IDLE;
      tx_tick_q     <= '0;
      tx_bit_q      <= '0;
      tx_shift_q    <= '0;
      tx_par_q      <= 1'b0;
      tx_q          <= 1'b1;
      rx_wr_q       <= '0;
      rx_rd_q       <= '0;
      rx_cnt_q      <= '0;
      tx_wr_q       <= '0;
      tx_rd_q       <= '0;
      tx_cnt_q      <= '0;
      err_frame_q   <= 1'b0;
      err_parity_q  <= 1'b0;
      err_overrun_q <= 1'b0;
    end else begin
      bcnt_q        <= bcnt_d;
      div_q         <= div_d;
      rx_meta_q     <= rx;
      rx_sync_q     <= rx_meta_q;
      rx_state_q    <= rx_state_d;
      rx_tick_q     <= rx_tick_d;
      rx_bit_q      <= rx_bit_d;
      rx_shift_q    <= rx_shift_d;
      rx_par_q      <= rx_par_d;
      tx_state_q    <= tx_state_d;
      tx_tick_q     <= tx_tick_d;
      tx_bit_q      <= tx_bit_d;
      tx_shift_q    <= tx_shift_d;
      tx_par_q      <= tx_par_d;
      tx_q          <= tx_d;
      rx_wr_q       <= rx_wr_d;
      rx_rd_q       <= rx_rd_d;
      rx_cnt_q      <= rx_cnt_d;
      tx_wr_q       <= tx_wr_d;
      tx_rd_q       <= tx_rd_d;
      tx_cnt_q      <= tx_cnt_d;
      err_frame_q   <= err_frame_d;
      err_parity_q  <= err_parity_d;
      err_overrun_q <= err_overrun_d;
    end
  end

  // FIFO storage needs no reset; validity is tracked by the counts
  always_ff @(posedge clk_100MHz) begin
    if (!reset && rx_push_ok) rx_mem_q[rx_wr_q] <= rx_shift_q;
    if (!reset && tx_push_ok) tx_mem_q[tx_wr_q] <= tx_data;
  end

  assign tx          = tx_q;
  assign tx_ready    = (tx_cnt_q != FULL_CNT);
  assign rx_valid    = (rx_cnt_q != '0);
  assign rx_data     = rx_valid ? rx_mem_q[rx_rd_q] : '0;
  assign rx_count    = rx_cnt_q;
  assign tx_count    = tx_cnt_q;
  assign err_frame   = err_frame_q;
  assign err_parity  = err_parity_q;
  assign err_overrun = err_overrun_q;

endmodule

// File: tb/tb_uart_stream_core.sv
// Directed bench for uart_stream_core: an 8N1 instance and an even-parity instance.
module tb_uart_stream_core;
  localparam int BAUD = 4;
  localparam int BIT  = 16 * BAUD;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset, err_clear;
  logic [12:0] baud_div;
  int          n_cmp = 0;
  int          n_bad = 0;

  // 8N1 instance
  logic       rx_a, tx_a, tx_valid, tx_ready, rx_valid, rx_ready;
  logic [7:0] tx_data, rx_data;
  logic [4:0] rx_count, tx_count;
  logic       err_frame, err_parity, err_overrun;

  // even-parity instance
  logic       rx_b, tx_b, tx_valid_p, tx_ready_p, rx_valid_p, rx_ready_p;
  logic [7:0] tx_data_p, rx_data_p;
  logic [4:0] rx_count_p, tx_count_p;
  logic       err_frame_p, err_parity_p, err_overrun_p;

  uart_stream_core dut (
    .clk_100MHz(clk), .reset(reset), .baud_div(baud_div), .rx(rx_a), .tx(tx_a),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .rx_count(rx_count), .tx_count(tx_count), .err_frame(err_frame),
    .err_parity(err_parity), .err_overrun(err_overrun), .err_clear(err_clear)
  );

  uart_stream_core #(.PARITY_EN(1), .PARITY_ODD(0)) dut_p (
    .clk_100MHz(clk), .reset(reset), .baud_div(baud_div), .rx(rx_b), .tx(tx_b),
    .tx_data(tx_data_p), .tx_valid(tx_valid_p), .tx_ready(tx_ready_p),
    .rx_data(rx_data_p), .rx_valid(rx_valid_p), .rx_ready(rx_ready_p),
    .rx_count(rx_count_p), .tx_count(tx_count_p), .err_frame(err_frame_p),
    .err_parity(err_parity_p), .err_overrun(err_overrun_p), .err_clear(err_clear)
  );

  task automatic set_rx(input bit sel, input logic v);
    if (sel) rx_b = v; else rx_a = v;
  endtask

  // Serial frame onto rx_a (sel=0) or rx_b (sel=1); a zero stop bit is shortened
  task automatic send_frame(input bit sel, input logic [7:0] d, input bit with_par,
                            input logic par, input logic stop);
    set_rx(sel, 1'b0); repeat (BIT) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      set_rx(sel, d[i]); repeat (BIT) @(negedge clk);
    end
    if (with_par) begin
      set_rx(sel, par); repeat (BIT) @(negedge clk);
    end
    set_rx(sel, stop);
    if (stop) begin
      repeat (BIT) @(negedge clk);
    end else begin
      repeat (40) @(negedge clk);
      set_rx(sel, 1'b1);
      repeat (BIT - 40) @(negedge clk);
    end
    repeat (BIT) @(negedge clk);
  endtask

  task automatic wait_tx_fall(output bit seen);
    seen = 1'b0;
    for (int i = 0; i < 400; i++) begin
      if (tx_a === 1'b0) begin seen = 1'b1; break; end
      @(negedge clk);
    end
  endtask

  task automatic pulse_err_clear();
    @(negedge clk); err_clear = 1'b1;
    @(negedge clk); err_clear = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; err_clear = 1'b0; baud_div = 13'(BAUD);
    rx_a = 1'b1; rx_b = 1'b1; tx_valid = 1'b0; tx_data = '0; rx_ready = 1'b0;
    tx_valid_p = 1'b0; tx_data_p = '0; rx_ready_p = 1'b0;
    repeat (3) @(negedge clk);
    n_cmp++; if (tx_a !== 1'b1) begin n_bad++; $display("FAIL reset_tx: got %b want 1", tx_a); end
    n_cmp++; if (tx_ready !== 1'b1) begin n_bad++; $display("FAIL reset_tx_ready: got %b want 1", tx_ready); end
    n_cmp++; if (rx_valid !== 1'b0) begin n_bad++; $display("FAIL reset_rx_valid: got %b want 0", rx_valid); end
    n_cmp++; if (rx_data !== 8'h00) begin n_bad++; $display("FAIL reset_rx_data: got %h want 00", rx_data); end
    n_cmp++; if (rx_count !== 5'd0 || tx_count !== 5'd0) begin
      n_bad++; $display("FAIL reset_counts: got rx %0d tx %0d want 0 0", rx_count, tx_count); end
    n_cmp++; if ({err_frame, err_parity, err_overrun} !== 3'b000) begin
      n_bad++; $display("FAIL reset_errs: got %b want 000", {err_frame, err_parity, err_overrun}); end
    reset = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic test_rx_basic();
    send_frame(1'b0, 8'h55, 1'b0, 1'b0, 1'b1);
    n_cmp++; if (rx_valid !== 1'b1) begin n_bad++; $display("FAIL rx55_valid: got %b want 1", rx_valid); end
    n_cmp++; if (rx_data !== 8'h55) begin n_bad++; $display("FAIL rx55_data: got %h want 55", rx_data); end
    n_cmp++; if (rx_count !== 5'd1) begin n_bad++; $display("FAIL rx55_count: got %0d want 1", rx_count); end
    n_cmp++; if ({err_frame, err_parity, err_overrun} !== 3'b000) begin
      n_bad++; $display("FAIL rx55_errs: got %b want 000", {err_frame, err_parity, err_overrun}); end
    rx_ready = 1'b1; @(negedge clk); rx_ready = 1'b0;
    n_cmp++; if (rx_valid !== 1'b0 || rx_data !== 8'h00 || rx_count !== 5'd0) begin
      n_bad++; $display("FAIL rx55_pop: got valid %b data %h count %0d want 0 00 0", rx_valid, rx_data, rx_count); end
  endtask

  task automatic test_tx_frame();
    bit seen;
    logic [9:0] exp_bits;
    exp_bits = {1'b1, 8'hA3, 1'b0};
    @(negedge clk); tx_data = 8'hA3; tx_valid = 1'b1;
    @(negedge clk); tx_valid = 1'b0;
    wait_tx_fall(seen);
    n_cmp++; if (!seen) begin n_bad++; $display("FAIL txA3_start: got no start bit want start bit"); end
    n_cmp++; if (tx_count !== 5'd0) begin n_bad++; $display("FAIL txA3_count_at_start: got %0d want 0", tx_count); end
    repeat (BIT / 2) @(negedge clk);
    for (int i = 0; i < 10; i++) begin
      n_cmp++; if (tx_a !== exp_bits[i]) begin
        n_bad++; $display("FAIL txA3_bit%0d: got %b want %b", i, tx_a, exp_bits[i]); end
      repeat (BIT) @(negedge clk);
    end
    n_cmp++; if (tx_a !== 1'b1) begin n_bad++; $display("FAIL txA3_idle: got %b want 1", tx_a); end
  endtask

  task automatic test_back_to_back();
    bit seen;
    logic [19:0] exp_bits;
    exp_bits = {1'b1, 8'h7E, 1'b0, 1'b1, 8'h81, 1'b0};
    @(negedge clk); tx_data = 8'h81; tx_valid = 1'b1;
    @(negedge clk); tx_data = 8'h7E;
    @(negedge clk); tx_valid = 1'b0;
    wait_tx_fall(seen);
    n_cmp++; if (!seen) begin n_bad++; $display("FAIL b2b_start: got no start bit want start bit"); end
    n_cmp++; if (tx_count !== 5'd1) begin n_bad++; $display("FAIL b2b_count: got %0d want 1", tx_count); end
    repeat (BIT / 2) @(negedge clk);
    for (int i = 0; i < 20; i++) begin
      n_cmp++; if (tx_a !== exp_bits[i]) begin
        n_bad++; $display("FAIL b2b_bit%0d: got %b want %b", i, tx_a, exp_bits[i]); end
      repeat (BIT) @(negedge clk);
    end
    n_cmp++; if (tx_a !== 1'b1 || tx_count !== 5'd0) begin
      n_bad++; $display("FAIL b2b_idle: got tx %b count %0d want 1 0", tx_a, tx_count); end
  endtask

  task automatic test_baud_min();
    bit seen;
    logic [9:0] exp_bits;
    exp_bits = {1'b1, 8'h0F, 1'b0};
    @(negedge clk); baud_div = 13'd1;
    repeat (8) @(negedge clk);
    tx_data = 8'h0F; tx_valid = 1'b1;
    @(negedge clk); tx_valid = 1'b0;
    wait_tx_fall(seen);
    n_cmp++; if (!seen) begin n_bad++; $display("FAIL baudmin_start: got no start bit want start bit"); end
    repeat (16) @(negedge clk);
    for (int i = 0; i < 10; i++) begin
      n_cmp++; if (tx_a !== exp_bits[i]) begin
        n_bad++; $display("FAIL baudmin_bit%0d: got %b want %b", i, tx_a, exp_bits[i]); end
      repeat (32) @(negedge clk);
    end
    repeat (16) @(negedge clk);
    baud_div = 13'(BAUD);
    repeat (8) @(negedge clk);
  endtask

  task automatic test_frame_error();
    send_frame(1'b0, 8'h3C, 1'b0, 1'b0, 1'b0);
    n_cmp++; if (err_frame !== 1'b1) begin n_bad++; $display("FAIL ferr_flag: got %b want 1", err_frame); end
    n_cmp++; if (rx_count !== 5'd0 || rx_valid !== 1'b0) begin
      n_bad++; $display("FAIL ferr_nopush: got count %0d valid %b want 0 0", rx_count, rx_valid); end
    pulse_err_clear();
    n_cmp++; if (err_frame !== 1'b0) begin n_bad++; $display("FAIL ferr_clear: got %b want 0", err_frame); end
  endtask

  task automatic test_glitch();
    @(negedge clk); rx_a = 1'b0;
    repeat (3 * BAUD) @(negedge clk);
    rx_a = 1'b1;
    repeat (2 * BIT) @(negedge clk);
    n_cmp++; if (rx_count !== 5'd0 || rx_valid !== 1'b0) begin
      n_bad++; $display("FAIL glitch_nopush: got count %0d valid %b want 0 0", rx_count, rx_valid); end
    n_cmp++; if ({err_frame, err_parity, err_overrun} !== 3'b000) begin
      n_bad++; $display("FAIL glitch_errs: got %b want 000", {err_frame, err_parity, err_overrun}); end
  endtask

  task automatic test_parity();
    send_frame(1'b1, 8'h07, 1'b1, 1'b0, 1'b1);
    n_cmp++; if (err_parity_p !== 1'b1) begin n_bad++; $display("FAIL par_flag: got %b want 1", err_parity_p); end
    n_cmp++; if (rx_count_p !== 5'd0) begin n_bad++; $display("FAIL par_nopush: got %0d want 0", rx_count_p); end
    n_cmp++; if (err_frame_p !== 1'b0) begin n_bad++; $display("FAIL par_noframe: got %b want 0", err_frame_p); end
    pulse_err_clear();
    n_cmp++; if (err_parity_p !== 1'b0) begin n_bad++; $display("FAIL par_clear: got %b want 0", err_parity_p); end
    send_frame(1'b1, 8'h07, 1'b1, 1'b1, 1'b1);
    n_cmp++; if (rx_count_p !== 5'd1 || rx_data_p !== 8'h07) begin
      n_bad++; $display("FAIL par_good: got count %0d data %h want 1 07", rx_count_p, rx_data_p); end
    n_cmp++; if (err_parity_p !== 1'b0) begin n_bad++; $display("FAIL par_good_flag: got %b want 0", err_parity_p); end
  endtask

  task automatic test_overrun();
    for (int b = 0; b < 17; b++) send_frame(1'b0, 8'(b), 1'b0, 1'b0, 1'b1);
    n_cmp++; if (rx_count !== 5'd16) begin n_bad++; $display("FAIL ovr_count: got %0d want 16", rx_count); end
    n_cmp++; if (err_overrun !== 1'b1) begin n_bad++; $display("FAIL ovr_flag: got %b want 1", err_overrun); end
    n_cmp++; if (rx_data !== 8'h00 || rx_valid !== 1'b1) begin
      n_bad++; $display("FAIL ovr_head: got data %h valid %b want 00 1", rx_data, rx_valid); end
    for (int i = 0; i < 16; i++) begin
      n_cmp++; if (rx_data !== 8'(i)) begin
        n_bad++; $display("FAIL ovr_pop%0d: got %h want %h", i, rx_data, 8'(i)); end
      rx_ready = 1'b1; @(negedge clk); rx_ready = 1'b0;
    end
    n_cmp++; if (rx_count !== 5'd0 || rx_valid !== 1'b0 || rx_data !== 8'h00) begin
      n_bad++; $display("FAIL ovr_drained: got count %0d valid %b data %h want 0 0 00", rx_count, rx_valid, rx_data); end
    rx_ready = 1'b1; @(negedge clk); rx_ready = 1'b0;
    n_cmp++; if (rx_count !== 5'd0) begin n_bad++; $display("FAIL ovr_pop_empty: got %0d want 0", rx_count); end
    n_cmp++; if (err_overrun !== 1'b1) begin n_bad++; $display("FAIL ovr_sticky: got %b want 1", err_overrun); end
    pulse_err_clear();
    n_cmp++; if (err_overrun !== 1'b0) begin n_bad++; $display("FAIL ovr_clear: got %b want 0", err_overrun); end
  endtask

  task automatic test_reset_mid_tx();
    bit seen;
    int lows;
    @(negedge clk); tx_data = 8'hF0; tx_valid = 1'b1;
    @(negedge clk); tx_data = 8'h0F;
    @(negedge clk); tx_valid = 1'b0;
    wait_tx_fall(seen);
    n_cmp++; if (!seen) begin n_bad++; $display("FAIL rst_tx_start: got no start bit want start bit"); end
    repeat (3 * BIT) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    n_cmp++; if (tx_a !== 1'b1 || tx_count !== 5'd0 || tx_ready !== 1'b1) begin
      n_bad++; $display("FAIL rst_tx_abort: got tx %b count %0d ready %b want 1 0 1", tx_a, tx_count, tx_ready); end
    reset = 1'b0;
    lows = 0;
    repeat (22 * BIT) begin
      @(negedge clk);
      if (tx_a !== 1'b1) lows++;
    end
    n_cmp++; if (lows !== 0) begin n_bad++; $display("FAIL rst_tx_silent: got %0d low cycles want 0", lows); end
    n_cmp++; if (rx_count !== 5'd0 || err_frame !== 1'b0) begin
      n_bad++; $display("FAIL rst_tx_rxside: got count %0d frame %b want 0 0", rx_count, err_frame); end
  endtask

  initial begin
    test_reset();
    test_rx_basic();
    test_tx_frame();
    test_back_to_back();
    test_baud_min();
    test_frame_error();
    test_glitch();
    test_parity();
    test_overrun();
    test_reset_mid_tx();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/uart_stream_core.md
UART_STREAM_CORE -- requirements
Module: uart_stream_core

Interface
REQ-001 Param DBITS, default 8, data bits per frame.
REQ-002 Param SB_TICK, default 16, stop-bit length in oversample ticks.
REQ-003 Param DIV_BITS, default 13, width of the runtime baud divisor.
REQ-004 Param FIFO_EXP, default 4, RX and TX FIFO depth is 2**FIFO_EXP each.
REQ-005 Param PARITY_EN, default 0, 1 = parity bit after data bits.
REQ-006 Param PARITY_ODD, default 0, 1 = odd parity, 0 = even (only when PARITY_EN=1).
REQ-007 clk_100MHz  in  1  single clock for all logic.
REQ-008 reset  in  1  synchronous, active-high reset.
REQ-009 baud_div  in  DIV_BITS  clk_100MHz cycles per oversample tick (16 ticks per bit).
REQ-010 rx  in  1  asynchronous serial input, idle high.
REQ-011 tx  out  1  serial output, idle high.
REQ-012 tx_data  in  DBITS  byte to transmit.
REQ-013 tx_valid  in  1  push request for tx_data.
REQ-014 tx_ready  out  1  TX FIFO not full.
REQ-015 rx_data  out  DBITS  head of RX FIFO (first-word-fall-through).
REQ-016 rx_valid  out  1  RX FIFO not empty.
REQ-017 rx_ready  in  1  pop request for RX FIFO.
REQ-018 rx_count, tx_count  out  FIFO_EXP+1 each  current FIFO occupancy.
REQ-019 err_frame, err_parity, err_overrun  out  1 each  sticky error flags.
REQ-020 err_clear  in  1  clears all sticky error flags.

Function
REQ-021 Baud gen: counter 0..baud_div-1, one-cycle tick on wrap; baud_div<2 treated as 2; new baud_div is taken at the next wrap.
REQ-022 rx passes a 2-FF synchronizer; all RX decisions use the synchronized value.
REQ-023 RX FSM IDLE->START on synced rx=0; START waits 7 ticks, then rx=0 -> DATA, else back to IDLE (glitch reject).
REQ-024 DATA samples DBITS bits LSB first, one per 16 ticks; then PARITY (if PARITY_EN), then STOP after SB_TICK ticks, then IDLE.
REQ-025 STOP sample 0 -> err_frame=1, byte discarded; parity mismatch -> err_parity=1, byte discarded; frame and parity errors may set together.
REQ-026 Good byte is pushed to the RX FIFO in the cycle STOP completes; if the FIFO is full and no pop occurs that cycle -> byte dropped, err_overrun=1, contents unchanged.
REQ-027 FIFO push and pop in the same cycle: both take effect, count unchanged; pop when empty is ignored; push when full is ignored.
REQ-028 TX push accepted when tx_valid and tx_ready; push while full is ignored, with no error flagged.
REQ-029 TX FSM IDLE/START/DATA/PARITY/STOP: in IDLE with TX FIFO non-empty, pop the head and enter START in the same cycle.
REQ-030 tx=0 for 16 ticks in START, DATA bits LSB first at 16 ticks each, parity bit, tx=1 for SB_TICK ticks; back-to-back frames need no idle gap.
REQ-031 Parity bit = XOR of data bits, inverted when PARITY_ODD=1.
REQ-032 Sticky flags: set on event, cleared by err_clear; set and clear in the same cycle -> set wins.
REQ-033 rx_data = 0 when rx_valid = 0.

Reset
REQ-034 reset=1 at a clk_100MHz edge: tx=1, tx_ready=1, rx_valid=0, rx_data=0, counts=0, all err=0, both FSMs IDLE, FIFOs emptied, baud counter=0.
REQ-035 Reset mid-frame aborts the frame with no partial push and no error flag; tx=1 from the next cycle.

Verification
REQ-036 baud_div=651, 8N1: drive 0x55 on rx -> rx_valid=1, rx_data=0x55, rx_count=1 about 10*16*651 cycles after the start edge.
REQ-037 Push 0xA3 -> tx: 0 for 16 ticks, then 1,1,0,0,0,1,0,1 at 16 ticks each, then 1; tx_count returns to 0 at START.
REQ-038 PARITY_EN=1, even: drive 0x07 with parity bit 0 -> err_parity=1, rx_count=0; err_clear pulse -> err_parity=0.
REQ-039 Drive a frame with stop bit 0 -> err_frame=1, no push; a 3-tick low glitch on rx -> no frame, no error.
REQ-040 Send 17 bytes 0x00..0x10 with FIFO_EXP=4 and no pops -> rx_count=16, err_overrun=1, rx_data=0x00; pop 16 times -> 0x00..0x0F in order.
REQ-041 Push 2 bytes, assert reset during the first frame's DATA state -> tx=1 the next cycle, tx_count=0, no further frames sent.
